// File: rtl/vm_pkg.sv
// Shared constants for the vending machine change path: coin codes, coin values,
// and the dispenser state encoding.
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam int NUM_COINS = 5;

  localparam logic [4:0] COIN_NONE = 5'b00000;
  localparam logic [4:0] COIN_1    = 5'b00001;
  localparam logic [4:0] COIN_2    = 5'b00010;
  localparam logic [4:0] COIN_5    = 5'b00100;
  localparam logic [4:0] COIN_10   = 5'b01000;
  localparam logic [4:0] COIN_20   = 5'b10000;

  localparam logic [4:0] VAL_1  = 5'd1;
  localparam logic [4:0] VAL_2  = 5'd2;
  localparam logic [4:0] VAL_5  = 5'd5;
  localparam logic [4:0] VAL_10 = 5'd10;
  localparam logic [4:0] VAL_20 = 5'd20;

  function automatic logic [4:0] coin_value(input logic [4:0] coin);
    logic [4:0] val;
    val = 5'd0;
    case (coin)
      COIN_1:  val = VAL_1;
      COIN_2:  val = VAL_2;
      COIN_5:  val = VAL_5;
      COIN_10: val = VAL_10;
      COIN_20: val = VAL_20;
      default: val = 5'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vm_coin_select.sv
// Greedy coin picker: largest denomination that fits the remaining amount and
// still has stock.
module vm_coin_select
  import vm_pkg::*;
(
  input  logic [4:0] i_remaining,
  input  logic [4:0] i_stock_nz,
  output logic [4:0] o_coin,
  output logic       o_found
);

  always_comb begin
    o_coin = COIN_NONE;
    if (i_stock_nz[4] && (i_remaining >= VAL_20))
      o_coin = COIN_20;
    else if (i_stock_nz[3] && (i_remaining >= VAL_10))
      o_coin = COIN_10;
    else if (i_stock_nz[2] && (i_remaining >= VAL_5))
      o_coin = COIN_5;
    else if (i_stock_nz[1] && (i_remaining >= VAL_2))
      o_coin = COIN_2;
    else if (i_stock_nz[0] && (i_remaining >= VAL_1))
      o_coin = COIN_1;
  end

  assign o_found = (o_coin != COIN_NONE);

endmodule

// File: rtl/vm_change_dispenser.sv
// Pays out a change amount one coin at a time over a req/ack hopper handshake,
// tracking per-denomination stock and flagging a hopper timeout as a sticky fault.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int STOCK_INIT  = 8,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_chng_in,
  input  logic       i_chng_vld,
  input  logic       i_refill,
  input  logic       i_hopper_ack,
  output logic [4:0] o_coin_out,
  output logic       o_coin_req,
  output logic       o_busy,
  output logic       o_done,
  output logic [4:0] o_short_amt,
  output logic       o_fault
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STOCK_FULL = CNT_W'(STOCK_INIT);

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_remaining;
  logic [4:0]       r_coin_out;
  logic [4:0]       r_short_amt;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_stock [NUM_COINS];

  logic [4:0] w_stock_nz;
  logic [4:0] w_sel_coin;
  logic       w_found;
  logic       w_ack;
  logic       w_timeout;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_nz
    assign w_stock_nz[g] = (r_stock[g] != '0);
  end

  vm_coin_select u_select (
    .i_remaining (r_remaining),
    .i_stock_nz  (w_stock_nz),
    .o_coin      (w_sel_coin),
    .o_found     (w_found)
  );

  // An ack on the final timer cycle still counts, so the timeout only fires without one.
  assign w_ack     = (r_state == ST_ISSUE) && i_hopper_ack;
  assign w_timeout = (r_state == ST_ISSUE) && !i_hopper_ack && (r_timer == TMR_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_chng_vld) w_next = ST_SELECT;
      ST_SELECT: w_next = (r_remaining != 5'd0 && w_found) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: begin
        if (w_ack)          w_next = ST_SELECT;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_DONE:   w_next = ST_IDLE;
      ST_FAULT:  w_next = ST_FAULT;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_coin_req  = (r_state == ST_ISSUE);
    o_busy      = (r_state != ST_IDLE);
    o_done      = (r_state == ST_DONE);
    o_fault     = (r_state == ST_FAULT);
    o_coin_out  = r_coin_out;
    o_short_amt = r_short_amt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_remaining <= 5'd0;
      r_coin_out  <= COIN_NONE;
      r_short_amt <= 5'd0;
      r_timer     <= '0;
      for (int i = 0; i < NUM_COINS; i++) r_stock[i] <= STOCK_FULL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_chng_vld) begin
            r_remaining <= i_chng_in;
            r_short_amt <= 5'd0;
          end else if (i_refill) begin
            for (int i = 0; i < NUM_COINS; i++) r_stock[i] <= STOCK_FULL;
          end
        end
        ST_SELECT: begin
          if (r_remaining != 5'd0) begin
            if (w_found) begin
              r_coin_out <= w_sel_coin;
              r_timer    <= '0;
            end else begin
              r_short_amt <= r_remaining;
            end
          end
        end
        ST_ISSUE: begin
          if (w_ack) begin
            r_remaining <= r_remaining - coin_value(r_coin_out);
            r_coin_out  <= COIN_NONE;
            for (int i = 0; i < NUM_COINS; i++)
              if (r_coin_out[i] && (r_stock[i] != '0)) r_stock[i] <= r_stock[i] - CNT_W'(1);
          end else if (w_timeout) begin
            r_coin_out <= COIN_NONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: table-driven payouts on a default and a
// single-coin-stock instance, plus hand sequences for timeout and async reset.
module tb_vm_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] chngIn = 5'd0;
  logic chngVld = 1'b0;
  logic refill = 1'b0;
  logic hopperAck = 1'b0;
  logic useOne = 1'b0;

  logic [4:0] coin0, coin1, short0, short1;
  logic req0, req1, busy0, busy1, done0, done1, fault0, fault1;

  logic [4:0] coinW, shortW;
  logic reqW, busyW, doneW, faultW;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vm_change_dispenser dut0 (
    .i_clk(clk), .i_rst(rst), .i_chng_in(chngIn),
    .i_chng_vld(chngVld & ~useOne), .i_refill(refill & ~useOne),
    .i_hopper_ack(hopperAck & ~useOne),
    .o_coin_out(coin0), .o_coin_req(req0), .o_busy(busy0), .o_done(done0),
    .o_short_amt(short0), .o_fault(fault0)
  );

  vm_change_dispenser #(.STOCK_INIT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_chng_in(chngIn),
    .i_chng_vld(chngVld & useOne), .i_refill(refill & useOne),
    .i_hopper_ack(hopperAck & useOne),
    .o_coin_out(coin1), .o_coin_req(req1), .o_busy(busy1), .o_done(done1),
    .o_short_amt(short1), .o_fault(fault1)
  );

  assign coinW  = useOne ? coin1  : coin0;
  assign shortW = useOne ? short1 : short0;
  assign reqW   = useOne ? req1   : req0;
  assign busyW  = useOne ? busy1  : busy0;
  assign doneW  = useOne ? done1  : done0;
  assign faultW = useOne ? fault1 : fault0;

  typedef struct {
    bit         useOne;
    bit         refillFirst;
    logic [4:0] amt;
    int         nCoins;
    logic [4:0] coins [4];
    logic [4:0] shortAmt;
  } vec_t;

  vec_t vecs [8];

  logic [4:0] seenCoins [8];
  int seenN, seenFirstReq, seenBusy;
  logic [4:0] seenShort;
  bit seenTimeout;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Loads one amount and acts as a hopper that acks each request one edge later.
  task automatic applyStimulus(input logic [4:0] amt);
    seenN = 0;
    seenFirstReq = -1;
    seenBusy = 0;
    seenShort = 5'd0;
    seenTimeout = 1'b1;
    chngIn = amt;
    chngVld = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      chngVld = 1'b0;
      refill = 1'b0;
      hopperAck = 1'b0;
      if (busyW) seenBusy++;
      if (reqW) begin
        if (seenFirstReq < 0) seenFirstReq = c;
        if (seenN < 8) seenCoins[seenN] = coinW;
        seenN++;
        hopperAck = 1'b1;
      end
      if (doneW) begin
        seenShort = shortW;
        seenTimeout = 1'b0;
        break;
      end
    end
    hopperAck = 1'b0;
  endtask

  task automatic pulseRefill();
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd18, 4, '{5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'd0};
    vecs[1] = '{1'b0, 1'b0, 5'd31, 3, '{5'b10000, 5'b01000, 5'b00001, 5'b00000}, 5'd0};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  0, '{5'b00000, 5'b00000, 5'b00000, 5'b00000}, 5'd0};
    vecs[3] = '{1'b0, 1'b0, 5'd7,  2, '{5'b00100, 5'b00010, 5'b00000, 5'b00000}, 5'd0};
    vecs[4] = '{1'b0, 1'b0, 5'd13, 3, '{5'b01000, 5'b00010, 5'b00001, 5'b00000}, 5'd0};
    vecs[5] = '{1'b1, 1'b0, 5'd20, 1, '{5'b10000, 5'b00000, 5'b00000, 5'b00000}, 5'd0};
    vecs[6] = '{1'b1, 1'b0, 5'd20, 4, '{5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'd2};
    vecs[7] = '{1'b1, 1'b1, 5'd3,  2, '{5'b00010, 5'b00001, 5'b00000, 5'b00000}, 5'd0};

    #1;
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_req", int'(req0), 0);
    checkOutput("reset_fault", int'(fault0), 0);
    checkOutput("reset_coin", int'(coin0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_done", int'(done0), 0);
    checkOutput("idle_short", int'(short0), 0);

    for (int v = 0; v < 8; v++) begin
      useOne = vecs[v].useOne;
      if (vecs[v].refillFirst) pulseRefill();
      applyStimulus(vecs[v].amt);
      checkOutput($sformatf("v%0d_timeout", v), int'(seenTimeout), 0);
      checkOutput($sformatf("v%0d_ncoins", v), seenN, vecs[v].nCoins);
      for (int k = 0; k < vecs[v].nCoins && k < seenN; k++)
        checkOutput($sformatf("v%0d_coin%0d", v, k), int'(seenCoins[k]), int'(vecs[v].coins[k]));
      checkOutput($sformatf("v%0d_short", v), int'(seenShort), int'(vecs[v].shortAmt));
      checkOutput($sformatf("v%0d_busycyc", v), seenBusy, 2 * vecs[v].nCoins + 2);
      if (vecs[v].nCoins > 0)
        checkOutput($sformatf("v%0d_firstreq", v), seenFirstReq, 2);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_done_pulse", v), int'(doneW), 0);
      checkOutput($sformatf("v%0d_busy_after", v), int'(busyW), 0);
      checkOutput($sformatf("v%0d_short_held", v), int'(shortW), int'(vecs[v].shortAmt));
    end

    checkOutput("stock0_1", int'(dut0.r_stock[0]), 5);
    checkOutput("stock0_2", int'(dut0.r_stock[1]), 5);
    checkOutput("stock0_5", int'(dut0.r_stock[2]), 6);
    checkOutput("stock0_10", int'(dut0.r_stock[3]), 5);
    checkOutput("stock0_20", int'(dut0.r_stock[4]), 7);

    // chng_vld beats refill on the same edge, so the empty 2/1 stocks stay empty
    useOne = 1'b1;
    refill = 1'b1;
    applyStimulus(5'd2);
    checkOutput("prio_ncoins", seenN, 0);
    checkOutput("prio_short", int'(seenShort), 2);
    checkOutput("prio_stock2", int'(dut1.r_stock[1]), 0);
    useOne = 1'b0;
    @(posedge clk); #1;

    // Hopper never acks: expect a fixed-length request then a sticky fault
    begin
      int reqCnt;
      reqCnt = 0;
      chngIn = 5'd5;
      chngVld = 1'b1;
      @(posedge clk); #1;
      chngVld = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (reqW) reqCnt++;
        else if (reqCnt > 0) break;
      end
      checkOutput("to_req_cycles", reqCnt, 15);
      checkOutput("to_fault", int'(fault0), 1);
      checkOutput("to_req_low", int'(req0), 0);
      checkOutput("to_busy", int'(busy0), 1);
      checkOutput("to_coin", int'(coin0), 0);
      chngIn = 5'd3;
      chngVld = 1'b1;
      hopperAck = 1'b1;
      @(posedge clk); #1;
      chngVld = 1'b0;
      hopperAck = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("to_sticky_fault", int'(fault0), 1);
      checkOutput("to_sticky_req", int'(req0), 0);
      checkOutput("to_sticky_busy", int'(busy0), 1);
      rst = 1'b1;
      #1;
      checkOutput("to_rst_fault", int'(fault0), 0);
      checkOutput("to_rst_busy", int'(busy0), 0);
      @(negedge clk);
      rst = 1'b0;
    end

    // Async reset in the middle of the first coin request
    begin
      bit sawReq;
      sawReq = 1'b0;
      @(posedge clk); #1;
      chngIn = 5'd25;
      chngVld = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        chngVld = 1'b0;
        if (req0) begin
          sawReq = 1'b1;
          break;
        end
      end
      checkOutput("mid_saw_req", int'(sawReq), 1);
      checkOutput("mid_coin20", int'(coin0), 16);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_req_drop", int'(req0), 0);
      checkOutput("mid_coin_clr", int'(coin0), 0);
      checkOutput("mid_busy", int'(busy0), 0);
      checkOutput("mid_done", int'(done0), 0);
      checkOutput("mid_fault", int'(fault0), 0);
      checkOutput("mid_short", int'(short0), 0);
      for (int i = 0; i < 5; i++)
        checkOutput($sformatf("mid_stock%0d", i), int'(dut0.r_stock[i]), 8);
      @(negedge clk);
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
